// File: rtl/instr_fetch_unit_if.sv
// Program-ROM / pipeline bus of the fetch stage.
//   master : fetch unit (drives rom_pc and the IF/ID outputs, samples ROM data and control)
//   slave  : ROM, hazard unit, execute stage, observers
// Signals:
//   rom_instr    ROM data for rom_pc (combinational)
//   stall        hold request from decode/hazard logic
//   redirect     taken branch/jump, flush and reload PC
//   redirect_pc  target PC when redirect is high
//   rom_pc       ROM address (current PC)
//   if_instr     IF/ID instruction register
//   if_pc        PC of the instruction in if_instr
//   if_valid     if_instr holds a live instruction
//   halted       fetch stopped on the halt encoding
//   fetch_count  instructions captured with if_valid set
interface instr_fetch_unit_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 9,
    parameter int CNT_W   = 16
);
    logic [INSTR_W-1:0] rom_instr;
    logic               stall;
    logic               redirect;
    logic [PC_W-1:0]    redirect_pc;
    logic [PC_W-1:0]    rom_pc;
    logic [INSTR_W-1:0] if_instr;
    logic [PC_W-1:0]    if_pc;
    logic               if_valid;
    logic               halted;
    logic [CNT_W-1:0]   fetch_count;

    modport master (
        input  rom_instr, stall, redirect, redirect_pc,
        output rom_pc, if_instr, if_pc, if_valid, halted, fetch_count
    );

    modport slave (
        output rom_instr, stall, redirect, redirect_pc,
        input  rom_pc, if_instr, if_pc, if_valid, halted, fetch_count
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage of the 9-bit pipelined CPU.
// Drives the PC to a combinational program ROM, captures the returned word
// into the IF/ID register, and handles stall, redirect (flush) and halt.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    instr_fetch_unit_if.master (ROM address/data, control, IF/ID outputs)
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_RUN  | fetching sequentially, one instruction per unstalled edge
// ST_HALT | halt word delivered; PC frozen, bubbles until a redirect
module instr_fetch_unit #(
    parameter int                 PC_W       = 8,
    parameter int                 INSTR_W    = 9,
    parameter logic [PC_W-1:0]    RESET_PC   = 8'd1,
    parameter logic [INSTR_W-1:0] HALT_INSTR = 9'b110111000,
    parameter int                 CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    instr_fetch_unit_if.master    bus
);

    typedef enum logic {ST_RUN, ST_HALT} state_t;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] if_instr_q, if_instr_d;
    logic [PC_W-1:0]    if_pc_q, if_pc_d;
    logic               if_valid_q, if_valid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_halt;

    assign is_halt = (bus.rom_instr == HALT_INSTR);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: redirect wins over stall, stall over halt/normal
    always_comb begin
        state_d = state_q;
        if (bus.redirect) begin
            state_d = ST_RUN;
        end else if (!bus.stall && state_q == ST_RUN && is_halt) begin
            state_d = ST_HALT;
        end
    end

    // Output logic
    always_comb begin
        bus.halted = (state_q == ST_HALT);
    end

    // Datapath next values
    always_comb begin
        pc_d       = pc_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        if_valid_d = if_valid_q;
        cnt_d      = cnt_q;
        if (bus.redirect) begin
            // Flush the wrong-path word; if_instr/if_pc keep their old contents
            pc_d       = bus.redirect_pc;
            if_valid_d = 1'b0;
        end else if (bus.stall) begin
            // everything holds
        end else if (state_q == ST_HALT) begin
            if_valid_d = 1'b0;
        end else begin
            if_instr_d = bus.rom_instr;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
            cnt_d      = cnt_q + CNT_W'(1);
            if (!is_halt) begin
                pc_d = pc_q + PC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            if_instr_q <= '0;
            if_pc_q    <= '0;
            if_valid_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            pc_q       <= pc_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
            if_valid_q <= if_valid_d;
            cnt_q      <= cnt_d;
        end
    end

    // rom_pc comes straight from the PC register, so stall/redirect never
    // reach the ROM address combinationally.
    assign bus.rom_pc      = pc_q;
    assign bus.if_instr    = if_instr_q;
    assign bus.if_pc       = if_pc_q;
    assign bus.if_valid    = if_valid_q;
    assign bus.fetch_count = cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    localparam logic [8:0] HALT = 9'h1B8;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    instr_fetch_unit_if ifc ();

    instr_fetch_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.master)
    );

    logic [8:0] rom [256];
    assign ifc.rom_instr = rom[ifc.rom_pc];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model of the architectural state
    logic [7:0]  m_pc;
    logic [8:0]  m_instr;
    logic [7:0]  m_ifpc;
    logic        m_valid;
    logic        m_halted;
    logic [15:0] m_cnt;

    function automatic logic [42:0] dut_vec();
        return {ifc.rom_pc, ifc.if_instr, ifc.if_pc, ifc.if_valid, ifc.halted, ifc.fetch_count};
    endfunction

    function automatic logic [42:0] mdl_vec();
        return {m_pc, m_instr, m_ifpc, m_valid, m_halted, m_cnt};
    endfunction

    task automatic model_reset();
        m_pc = 8'd1; m_instr = '0; m_ifpc = '0; m_valid = 0; m_halted = 0; m_cnt = '0;
    endtask

    task automatic fill_rom();
        for (int i = 0; i < 256; i++) begin
            rom[i] = 9'($urandom);
            if (rom[i] == HALT) rom[i] = rom[i] ^ 9'h001;
        end
    endtask

    // Drive one cycle of inputs, advance the model by the fetch rules, settle after the edge
    task automatic cyc(input logic s, input logic r, input logic [7:0] rpc);
        logic [8:0] w;
        ifc.stall = s; ifc.redirect = r; ifc.redirect_pc = rpc;
        if (r) begin
            m_pc = rpc; m_valid = 0; m_halted = 0;
        end else if (s) begin
        end else if (m_halted) begin
            m_valid = 0;
        end else begin
            w = rom[m_pc];
            m_instr = w; m_ifpc = m_pc; m_valid = 1; m_cnt = m_cnt + 16'd1;
            if (w == HALT) m_halted = 1;
            else m_pc = m_pc + 8'd1;
        end
        @(posedge clk);
        #1;
        ifc.stall = 0; ifc.redirect = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        ifc.stall = 0; ifc.redirect = 0; ifc.redirect_pc = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (dut_vec() !== mdl_vec()) begin
            errors++;
            $display("FAIL reset: got %h want %h", dut_vec(), mdl_vec());
        end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_free_run();
        rom[1] = 9'h120; rom[2] = 9'h101; rom[3] = 9'h0C0;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0);
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL free_run[%0d]: got %h want %h", i, dut_vec(), mdl_vec());
            end
        end
        checks++;
        if (ifc.fetch_count !== 16'd3 || ifc.rom_pc !== 8'd4 || ifc.if_instr !== 9'h0C0) begin
            errors++;
            $display("FAIL free_run_end: cnt %0d pc %h instr %h want 3 04 0c0",
                     ifc.fetch_count, ifc.rom_pc, ifc.if_instr);
        end
    endtask

    task automatic test_stall();
        cyc(0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            cyc(1, 0, 0);
            checks++;
            if (dut_vec() !== mdl_vec() || ifc.rom_pc !== 8'd5) begin
                errors++;
                $display("FAIL stall[%0d]: got %h want %h", i, dut_vec(), mdl_vec());
            end
        end
        cyc(0, 0, 0);
        checks++;
        if (dut_vec() !== mdl_vec() || ifc.rom_pc !== 8'd6 || ifc.if_pc !== 8'd5) begin
            errors++;
            $display("FAIL stall_release: got %h want %h", dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_redirect_stall();
        for (int i = 0; i < 20 && m_pc != 8'h0D; i++) cyc(0, 0, 0);
        checks++;
        if (ifc.rom_pc !== 8'h0D) begin
            errors++;
            $display("FAIL reach_0d: got %h want 0d", ifc.rom_pc);
        end
        cyc(1, 1, 8'h0A);
        checks++;
        if (dut_vec() !== mdl_vec() || ifc.rom_pc !== 8'h0A || ifc.if_valid !== 1'b0) begin
            errors++;
            $display("FAIL redirect_stall: got %h want %h", dut_vec(), mdl_vec());
        end
        cyc(0, 0, 0);
        checks++;
        if (dut_vec() !== mdl_vec() || ifc.if_pc !== 8'h0A || ifc.if_valid !== 1'b1) begin
            errors++;
            $display("FAIL redirect_fetch: got %h want %h", dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_halt();
        logic [15:0] cnt_at_halt;
        rom[17] = HALT;
        cyc(0, 1, 8'd16);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        checks++;
        if (dut_vec() !== mdl_vec() || ifc.if_instr !== HALT || ifc.if_pc !== 8'd17
            || ifc.if_valid !== 1'b1 || ifc.halted !== 1'b1 || ifc.rom_pc !== 8'd17) begin
            errors++;
            $display("FAIL halt_take: got %h want %h", dut_vec(), mdl_vec());
        end
        cnt_at_halt = ifc.fetch_count;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0);
            checks++;
            if (dut_vec() !== mdl_vec() || ifc.if_valid !== 1'b0 || ifc.fetch_count !== cnt_at_halt) begin
                errors++;
                $display("FAIL halt_hold[%0d]: got %h want %h", i, dut_vec(), mdl_vec());
            end
        end
    endtask

    task automatic test_resume_and_wrap();
        cyc(0, 1, 8'h0B);
        checks++;
        if (dut_vec() !== mdl_vec() || ifc.halted !== 1'b0 || ifc.rom_pc !== 8'h0B) begin
            errors++;
            $display("FAIL resume: got %h want %h", dut_vec(), mdl_vec());
        end
        cyc(0, 0, 0);
        checks++;
        if (dut_vec() !== mdl_vec() || ifc.if_pc !== 8'h0B || ifc.rom_pc !== 8'h0C) begin
            errors++;
            $display("FAIL resume_fetch: got %h want %h", dut_vec(), mdl_vec());
        end
        rom[8'hFF] = 9'h055;
        cyc(0, 1, 8'hFF);
        cyc(0, 0, 0);
        checks++;
        if (dut_vec() !== mdl_vec() || ifc.rom_pc !== 8'h00 || ifc.if_pc !== 8'hFF) begin
            errors++;
            $display("FAIL pc_wrap: got %h want %h", dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_halt_corners();
        // HALT fetched in a redirect shadow is discarded by the redirect
        rom[8'h40] = HALT;
        cyc(0, 1, 8'h40);
        cyc(0, 0, 0);
        cyc(0, 1, 8'h20);
        checks++;
        if (dut_vec() !== mdl_vec() || ifc.halted !== 1'b0 || ifc.if_valid !== 1'b0) begin
            errors++;
            $display("FAIL halt_shadow: got %h want %h", dut_vec(), mdl_vec());
        end
        // Stall on the HALT edge defers it until the stall drops
        rom[8'h50] = HALT;
        cyc(0, 1, 8'h50);
        cyc(1, 0, 0);
        checks++;
        if (dut_vec() !== mdl_vec() || ifc.halted !== 1'b0) begin
            errors++;
            $display("FAIL stall_on_halt: got %h want %h", dut_vec(), mdl_vec());
        end
        cyc(0, 0, 0);
        checks++;
        if (dut_vec() !== mdl_vec() || ifc.halted !== 1'b1 || ifc.if_instr !== HALT) begin
            errors++;
            $display("FAIL halt_after_stall: got %h want %h", dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_random();
        logic s, r;
        for (int i = 0; i < 256; i++) if ($urandom_range(0, 19) == 0) rom[i] = HALT;
        for (int i = 0; i < 400; i++) begin
            s = ($urandom_range(0, 4) == 0);
            r = ($urandom_range(0, 9) == 0);
            cyc(s, r, 8'($urandom));
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL random[%0d]: got %h want %h", i, dut_vec(), mdl_vec());
            end
        end
    endtask

    task automatic test_async_reset();
        fill_rom();
        cyc(0, 1, 8'h2F);
        cyc(0, 0, 0);
        #3;
        rst_n = 0;
        model_reset();
        #1;
        checks++;
        if (dut_vec() !== mdl_vec() || ifc.rom_pc !== 8'd1) begin
            errors++;
            $display("FAIL async_reset: got %h want %h", dut_vec(), mdl_vec());
        end
        @(posedge clk);
        #1;
        rst_n = 1;
        cyc(0, 0, 0);
        checks++;
        if (dut_vec() !== mdl_vec() || ifc.if_pc !== 8'd1 || ifc.if_valid !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_fetch: got %h want %h", dut_vec(), mdl_vec());
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        fill_rom();
        test_reset();
        test_free_run();
        test_stall();
        test_redirect_stall();
        test_halt();
        test_resume_and_wrap();
        test_halt_corners();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front-end fetch stage of the 9-bit pipelined CPU; the initiator side of the program ROM interface.
- Drives the 8-bit PC to the program ROM and captures the returned 9-bit instruction into the IF/ID pipeline register.
- Advances the PC sequentially and handles stall, branch/jump redirect (flush) and halt.
- Also maintains a fetched-instruction counter for bench/perf visibility.

Parameters:
- PC_W, 8, width of program counter / ROM address
- INSTR_W, 9, instruction width
- RESET_PC, 8'd1, first instruction address (program images start at index 1)
- HALT_INSTR, 9'b110111000, encoding that stops fetch
- CNT_W, 16, width of fetch counter

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- rom_instr  in  INSTR_W  instruction returned by ROM for rom_pc (combinational, same cycle)
- stall  in  1  hold request from decode/hazard unit
- redirect  in  1  taken branch/jump from execute; flush and load new PC
- redirect_pc  in  PC_W  target PC when redirect=1
- rom_pc  out  PC_W  address to ROM (= pc_reg)
- if_instr  out  INSTR_W  IF/ID instruction register
- if_pc  out  PC_W  PC of instruction in if_instr
- if_valid  out  1  if_instr holds a live instruction (0 = bubble)
- halted  out  1  fetch stopped on HALT_INSTR
- fetch_count  out  CNT_W  count of instructions captured with if_valid=1

Behaviour:
- Reset (async, rst_n=0): pc_reg=RESET_PC, if_instr=0, if_pc=0, if_valid=0, halted=0, fetch_count=0. Deassertion mid-program restarts at RESET_PC on the next edge.
- rom_pc = pc_reg combinationally. The ROM is combinational, so there is one cycle from pc_reg to if_instr.
- Priority per rising edge: redirect > stall > halted > normal.
- redirect=1 (regardless of stall/halted):
  - pc_reg <= redirect_pc
  - if_valid <= 0 (flush wrong-path fetch)
  - halted <= 0
  - if_instr/if_pc hold
  - fetch_count unchanged
- stall=1, redirect=0: all registers hold, including if_valid and fetch_count.
- halted=1, no redirect/stall: pc_reg holds, if_valid <= 0.
- normal:
  - if_instr <= rom_instr, if_pc <= pc_reg, if_valid <= 1, fetch_count += 1
  - if rom_instr == HALT_INSTR: pc_reg holds, halted <= 1. The HALT itself is delivered with if_valid=1 exactly once.
  - else pc_reg <= pc_reg + 1, modulo 2^PC_W (0xFF wraps to 0x00, no flag).
- fetch_count wraps modulo 2^CNT_W silently.
- HALT fetched in a redirect shadow: the redirect on the following edge clears halted and discards the HALT (if_valid=0).
- stall asserted on the same edge HALT is presented: nothing captured, halted stays 0. HALT is taken when stall drops.
- No combinational path from stall/redirect to rom_pc.

Test Plan:
- Reset then free-run with ROM [1]=0x120,[2]=0x101,[3]=0x0C0 -> rom_pc 1,2,3,4 on successive cycles; if_pc 1,2,3 with if_valid=1; fetch_count=3 after 3 edges.
- stall high for 2 cycles at pc=5 -> rom_pc stays 5, if_instr/if_pc/if_valid/fetch_count unchanged; resumes at 5→6 after release.
- redirect=1, redirect_pc=0x0A while stall=1 at pc=0x0D -> next cycle rom_pc=0x0A, if_valid=0; following cycle if_pc=0x0A, if_valid=1.
- ROM[17]=0x1B8 (HALT) -> if_instr=0x1B8, if_pc=17, if_valid=1 once; halted=1; rom_pc stays 17; if_valid=0 thereafter; fetch_count frozen.
- Halted, then redirect to 0x0B -> halted=0, rom_pc=0x0B, fetch resumes; also pc_reg=0xFF normal step -> rom_pc=0x00.
- rst_n pulsed low mid-cycle at pc=0x30 -> outputs clear immediately (async); first edge after release fetches from pc=1.
